// File: rtl/turn_sequencer.sv
`timescale 1ns/1ps
// turn_sequencer
// Turn controller for the reversi game core. Rotates the active player,
// issues a one-cycle turn_start pulse per turn, counts consecutive passes,
// optionally forces a pass when a player stalls past TIMEOUT cycles, and
// ends the game on a full board or when every player has passed in a row.
// All outputs come straight from registers.

module turn_sequencer #(
  parameter int NUM_PLAYERS = 2,
  parameter int TIMEOUT     = 0,
  parameter int TURN_W      = 7,
  localparam int PW         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              initialize,
  input  logic              move_done,
  input  logic              pass,
  input  logic              board_full,
  output logic [PW-1:0]     current_player,
  output logic              turn_start,
  output logic              awaiting_move,
  output logic              timed_out,
  output logic [3:0]        consec_passes,
  output logic [TURN_W-1:0] turn_count,
  output logic              game_over
);

  // Timer is kept at least one bit wide so the design stays legal with the
  // timer disabled; in that case it is held at zero.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TW-1:0]     TIMER_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : {TW{1'b0}};
  localparam logic [PW-1:0]     LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [3:0]        PASS_LIMIT  = 4'(NUM_PLAYERS);
  localparam logic [TURN_W-1:0] TURN_MAX    = {TURN_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [PW-1:0]       player_r;
  logic [PW-1:0]       player_s;
  logic [TURN_W-1:0]   turn_cnt_r;
  logic [TURN_W-1:0]   turn_cnt_s;
  logic [3:0]          passes_r;
  logic [3:0]          passes_s;
  logic [3:0]          passes_inc_s;
  logic [TW-1:0]       timer_r;
  logic [TW-1:0]       timer_s;
  logic                expire_s;
  logic                timed_out_s;
  logic                turn_start_r;
  logic                awaiting_r;
  logic                timed_out_r;
  logic                game_over_r;

  // Wrap-around successor of a player index.
  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_PLAYER) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Turn counter increment that sticks at all-ones.
  function automatic logic [TURN_W-1:0] sat_inc(input logic [TURN_W-1:0] c);
    logic [TURN_W-1:0] n;
    if (c == TURN_MAX) begin
      n = c;
    end else begin
      n = c + TURN_W'(1);
    end
    return n;
  endfunction

  // Next-state and next-datapath decision for the turn flow.
  always_comb begin
    state_s      = state_r;
    player_s     = player_r;
    turn_cnt_s   = turn_cnt_r;
    passes_s     = passes_r;
    timer_s      = timer_r;
    timed_out_s  = 1'b0;
    passes_inc_s = passes_r + 4'd1;
    if (TIMEOUT > 0) begin
      expire_s = (timer_r == TIMER_LAST);
    end else begin
      expire_s = 1'b0;
    end

    if (initialize) begin
      state_s    = ST_START;
      player_s   = {PW{1'b0}};
      turn_cnt_s = {TURN_W{1'b0}};
      passes_s   = 4'd0;
      timer_s    = {TW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_START: begin
          state_s = ST_WAIT;
          timer_s = {TW{1'b0}};
        end
        ST_WAIT: begin
          if (board_full) begin
            state_s = ST_OVER;
            timer_s = {TW{1'b0}};
          end else if (move_done) begin
            passes_s   = 4'd0;
            player_s   = next_player(player_r);
            turn_cnt_s = sat_inc(turn_cnt_r);
            timer_s    = {TW{1'b0}};
            state_s    = ST_START;
          end else if (pass || expire_s) begin
            // An explicit pass on the expiry edge is a normal pass.
            passes_s    = passes_inc_s;
            timed_out_s = ~pass;
            timer_s     = {TW{1'b0}};
            if (passes_inc_s == PASS_LIMIT) begin
              state_s = ST_OVER;
            end else begin
              player_s   = next_player(player_r);
              turn_cnt_s = sat_inc(turn_cnt_r);
              state_s    = ST_START;
            end
          end else begin
            if (TIMEOUT > 0) begin
              timer_s = timer_r + TW'(1);
            end else begin
              timer_s = {TW{1'b0}};
            end
          end
        end
        ST_OVER: begin
          state_s = ST_OVER;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath registers and registered status flags decoded from the next state.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      player_r     <= {PW{1'b0}};
      turn_cnt_r   <= {TURN_W{1'b0}};
      passes_r     <= 4'd0;
      timer_r      <= {TW{1'b0}};
      turn_start_r <= 1'b0;
      awaiting_r   <= 1'b0;
      timed_out_r  <= 1'b0;
      game_over_r  <= 1'b0;
    end else begin
      player_r     <= player_s;
      turn_cnt_r   <= turn_cnt_s;
      passes_r     <= passes_s;
      timer_r      <= timer_s;
      turn_start_r <= (state_s == ST_START);
      awaiting_r   <= (state_s == ST_WAIT);
      timed_out_r  <= timed_out_s;
      game_over_r  <= (state_s == ST_OVER);
    end
  end

  assign current_player = player_r;
  assign turn_start     = turn_start_r;
  assign awaiting_move  = awaiting_r;
  assign timed_out      = timed_out_r;
  assign consec_passes  = passes_r;
  assign turn_count     = turn_cnt_r;
  assign game_over      = game_over_r;

endmodule

// File: tb/tb_turn_sequencer.sv
`timescale 1ns/1ps
// tb_turn_sequencer
// Two sequencers share one stimulus stream: instance A (2 players, no timer,
// 7-bit turn count) and instance B (3 players, TIMEOUT=5, 2-bit turn count).
// A behavioural model of the turn rules predicts every output of both.

module tb_turn_sequencer;

  logic clk;
  logic resetn;
  logic initialize;
  logic move_done;
  logic pass;
  logic board_full;

  logic       cp_a_s;
  logic       ts_a_s;
  logic       aw_a_s;
  logic       to_a_s;
  logic [3:0] cs_a_s;
  logic [6:0] tc_a_s;
  logic       go_a_s;

  logic [1:0] cp_b_s;
  logic       ts_b_s;
  logic       aw_b_s;
  logic       to_b_s;
  logic [3:0] cs_b_s;
  logic [1:0] tc_b_s;
  logic       go_b_s;

  logic [18:0] obs_s [2];

  int checks;
  int errors;

  // Behavioural model state, one slot per instance.
  bit m_started [2];
  bit m_over    [2];
  bit m_dead    [2];
  bit m_to      [2];
  int m_player  [2];
  int m_turns   [2];
  int m_passes  [2];
  int m_waited  [2];

  turn_sequencer #(.NUM_PLAYERS(2), .TIMEOUT(0), .TURN_W(7)) u_a (
    .clk(clk), .resetn(resetn), .initialize(initialize), .move_done(move_done),
    .pass(pass), .board_full(board_full), .current_player(cp_a_s),
    .turn_start(ts_a_s), .awaiting_move(aw_a_s), .timed_out(to_a_s),
    .consec_passes(cs_a_s), .turn_count(tc_a_s), .game_over(go_a_s)
  );

  turn_sequencer #(.NUM_PLAYERS(3), .TIMEOUT(5), .TURN_W(2)) u_b (
    .clk(clk), .resetn(resetn), .initialize(initialize), .move_done(move_done),
    .pass(pass), .board_full(board_full), .current_player(cp_b_s),
    .turn_start(ts_b_s), .awaiting_move(aw_b_s), .timed_out(to_b_s),
    .consec_passes(cs_b_s), .turn_count(tc_b_s), .game_over(go_b_s)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack each instance's outputs into a common comparison layout.
  always_comb begin
    obs_s[0] = {2'b00, cp_a_s, ts_a_s, aw_a_s, to_a_s, cs_a_s, 1'b0, tc_a_s, go_a_s};
    obs_s[1] = {1'b0, cp_b_s, ts_b_s, aw_b_s, to_b_s, cs_b_s, 6'b000000, tc_b_s, go_b_s};
  end

  function automatic int np_of(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic int timeout_of(input int i);
    return (i == 0) ? 0 : 5;
  endfunction

  function automatic int tmax_of(input int i);
    return (i == 0) ? 127 : 3;
  endfunction

  function automatic logic [18:0] exp_vec(input int i);
    logic ts;
    logic aw;
    ts = m_started[i] && !m_over[i] && m_dead[i];
    aw = m_started[i] && !m_over[i] && !m_dead[i];
    return {3'(m_player[i]), ts, aw, m_to[i], 4'(m_passes[i]), 8'(m_turns[i]), m_over[i]};
  endfunction

  task automatic model_reset(input int i);
    m_started[i] = 1'b0;
    m_over[i]    = 1'b0;
    m_dead[i]    = 1'b0;
    m_to[i]      = 1'b0;
    m_player[i]  = 0;
    m_turns[i]   = 0;
    m_passes[i]  = 0;
    m_waited[i]  = 0;
  endtask

  task automatic model_advance(input int i);
    m_player[i] = (m_player[i] + 1) % np_of(i);
    if (m_turns[i] < tmax_of(i)) m_turns[i] = m_turns[i] + 1;
    m_waited[i] = 0;
    m_dead[i]   = 1'b1;
  endtask

  // One clock of the game rules as seen from the players' side.
  task automatic model_step(input int i, input logic i_init, input logic i_md,
                            input logic i_ps, input logic i_bf);
    bit expire;
    m_to[i] = 1'b0;
    if (i_init) begin
      m_started[i] = 1'b1;
      m_over[i]    = 1'b0;
      m_dead[i]    = 1'b1;
      m_player[i]  = 0;
      m_turns[i]   = 0;
      m_passes[i]  = 0;
      m_waited[i]  = 0;
    end else if (m_started[i] && !m_over[i]) begin
      if (m_dead[i]) begin
        m_dead[i]   = 1'b0;
        m_waited[i] = 0;
      end else begin
        expire = (timeout_of(i) > 0) && (m_waited[i] + 1 == timeout_of(i));
        if (i_bf) begin
          m_over[i] = 1'b1;
        end else if (i_md) begin
          m_passes[i] = 0;
          model_advance(i);
        end else if (i_ps || expire) begin
          m_passes[i] = m_passes[i] + 1;
          m_to[i]     = !i_ps;
          if (m_passes[i] == np_of(i)) m_over[i] = 1'b1;
          else model_advance(i);
        end else begin
          m_waited[i] = m_waited[i] + 1;
        end
      end
    end
  endtask

  // Drive inputs for one edge, update the model, and land 1 ns past the edge.
  task automatic tick(input logic i_init, input logic i_md, input logic i_ps, input logic i_bf);
    initialize = i_init;
    move_done  = i_md;
    pass       = i_ps;
    board_full = i_bf;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (resetn) model_reset(i);
      else model_step(i, i_init, i_md, i_ps, i_bf);
    end
    #1;
    initialize = 1'b0;
    move_done  = 1'b0;
    pass       = 1'b0;
    board_full = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    initialize = 1'b0; move_done = 1'b0; pass = 1'b0; board_full = 1'b0;
    for (int i = 0; i < 2; i++) model_reset(i);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_s[i] !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %h expected 00000", i, obs_s[i]);
      end
    end
    @(negedge clk);
    resetn = 1'b0;
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_s[i] !== exp_vec(i)) begin
        errors++;
        $display("FAIL idle_ignores_input[%0d]: got %h expected %h", i, obs_s[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_rotation();
    logic [4:0] seq;
    int n_ts;
    n_ts = 0;
    seq  = 5'd0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    if (ts_a_s) begin seq[n_ts] = cp_a_s; n_ts++; end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      if (ts_a_s && n_ts < 5) begin seq[n_ts] = cp_a_s; n_ts++; end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (n_ts !== 5) begin errors++; $display("FAIL rotation_ts_count: got %0d expected 5", n_ts); end
    checks++;
    if (seq !== 5'b01010) begin errors++; $display("FAIL rotation_player_seq: got %b expected 01010", seq); end
    checks++;
    if (tc_a_s !== 7'd4) begin errors++; $display("FAIL rotation_turn_count: got %0d expected 4", tc_a_s); end
    checks++;
    if (cs_a_s !== 4'd0) begin errors++; $display("FAIL rotation_passes: got %0d expected 0", cs_a_s); end
    checks++;
    if (cp_b_s !== 2'd1) begin errors++; $display("FAIL rotation_player3: got %0d expected 1", cp_b_s); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (tc_b_s !== 2'd3) begin errors++; $display("FAIL saturate_turn_count: got %0d expected 3", tc_b_s); end
    checks++;
    if (tc_a_s !== 7'd5) begin errors++; $display("FAIL fifth_turn_count: got %0d expected 5", tc_a_s); end
  endtask

  task automatic test_passes();
    int ev [6];
    int exp_cs [6];
    ev     = '{1, 1, 2, 1, 1, 1};
    exp_cs = '{1, 2, 0, 1, 2, 3};
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      tick(1'b0, ev[k] == 2, ev[k] == 1, 1'b0);
      checks++;
      if (cs_b_s !== 4'(exp_cs[k])) begin
        errors++;
        $display("FAIL passes_count[%0d]: got %0d expected %0d", k, cs_b_s, exp_cs[k]);
      end
      checks++;
      if (go_b_s !== (k == 5)) begin
        errors++;
        $display("FAIL passes_game_over[%0d]: got %0d expected %0d", k, go_b_s, k == 5);
      end
      if (k < 5) tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({cp_b_s, cs_b_s, go_b_s, aw_b_s} !== {2'd2, 4'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL passes_frozen: got cp=%0d cs=%0d go=%0d aw=%0d expected cp=2 cs=3 go=1 aw=0",
               cp_b_s, cs_b_s, go_b_s, aw_b_s);
    end
  endtask

  task automatic test_timeout();
    int first_to;
    bit any_to;
    first_to = -1;
    any_to   = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (to_b_s && first_to < 0) first_to = n;
    end
    checks++;
    if (first_to !== 6) begin errors++; $display("FAIL timeout_edge: got %0d expected 6", first_to); end
    checks++;
    if ({cp_b_s, cs_b_s, ts_b_s} !== {2'd1, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL timeout_effect: got cp=%0d cs=%0d ts=%0d expected cp=1 cs=1 ts=1", cp_b_s, cs_b_s, ts_b_s);
    end
    checks++;
    if (to_a_s !== 1'b0 || aw_a_s !== 1'b1) begin
      errors++;
      $display("FAIL timer_disabled: got to=%0d aw=%0d expected to=0 aw=1", to_a_s, aw_a_s);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (to_b_s) any_to = 1'b1;
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    if (to_b_s) any_to = 1'b1;
    checks++;
    if (any_to !== 1'b0) begin errors++; $display("FAIL move_beats_timeout: got timed_out=1 expected 0"); end
    checks++;
    if ({cp_b_s, cs_b_s} !== {2'd2, 4'd0}) begin
      errors++;
      $display("FAIL move_beats_timeout_state: got cp=%0d cs=%0d expected cp=2 cs=0", cp_b_s, cs_b_s);
    end
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({cp_a_s, cs_a_s, tc_a_s} !== {1'b1, 4'd0, 7'd1}) begin
      errors++;
      $display("FAIL simultaneous: got cp=%0d cs=%0d tc=%0d expected cp=1 cs=0 tc=1", cp_a_s, cs_a_s, tc_a_s);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({cp_a_s, tc_a_s, ts_a_s, aw_a_s} !== {1'b1, 7'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL move_in_start: got cp=%0d tc=%0d ts=%0d aw=%0d expected cp=1 tc=1 ts=0 aw=1",
               cp_a_s, tc_a_s, ts_a_s, aw_a_s);
    end
  endtask

  task automatic test_board_full();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({go_a_s, tc_a_s, cp_a_s, aw_a_s} !== {1'b1, 7'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL board_full: got go=%0d tc=%0d cp=%0d aw=%0d expected go=1 tc=1 cp=1 aw=0",
               go_a_s, tc_a_s, cp_a_s, aw_a_s);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({go_a_s, cp_a_s, ts_a_s, tc_a_s} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL restart_after_over: got go=%0d cp=%0d ts=%0d tc=%0d expected go=0 cp=0 ts=1 tc=0",
               go_a_s, cp_a_s, ts_a_s, tc_a_s);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    resetn = 1'b1;
    for (int i = 0; i < 2; i++) model_reset(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_s[i] !== 19'd0) begin
        errors++;
        $display("FAIL async_reset[%0d]: got %h expected 00000", i, obs_s[i]);
      end
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    resetn = 1'b0;
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_s[i] !== exp_vec(i)) begin
        errors++;
        $display("FAIL after_reset_idle[%0d]: got %h expected %h", i, obs_s[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_random();
    logic r_init;
    logic r_md;
    logic r_ps;
    logic r_bf;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 600; n++) begin
      r_init = ($urandom_range(24, 0) == 0);
      r_bf   = ($urandom_range(59, 0) == 0);
      r_md   = ($urandom_range(3, 0) == 0);
      r_ps   = ($urandom_range(5, 0) == 0);
      tick(r_init, r_md, r_ps, r_bf);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_s[i] !== exp_vec(i)) begin
          errors++;
          $display("FAIL random[%0d] cycle %0d: got %h expected %h", i, n, obs_s[i], exp_vec(i));
        end
      end
    end
  endtask

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rotation();
    test_passes();
    test_timeout();
    test_simultaneous();
    test_board_full();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
